// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_reg_bridge
//  Description : Serial command engine. Pops bytes from a UART rx FIFO,
//                decodes 'W' addr data / 'R' addr packets, performs one
//                register-bus access and pushes a one-byte response into
//                the UART tx FIFO. Unknown commands and inter-byte timeouts
//                bump a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_bridge #(
   parameter int BITS_d         = 8,
   parameter int ADDR_BITS      = 8,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BITS_d-1:0]    r_data,
   input  logic                 rx_empty,
   output logic                 rd_uart,
   output logic [BITS_d-1:0]    w_data,
   output logic                 wr_uart,
   input  logic                 tx_full,
   output logic [ADDR_BITS-1:0] reg_addr,
   output logic [BITS_d-1:0]    reg_wdata,
   output logic                 reg_we,
   output logic                 reg_re,
   input  logic [BITS_d-1:0]    reg_rdata,
   output logic [7:0]           err_count
);

   localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TCNT_W-1:0] c_TIMEOUT = TCNT_W'(TIMEOUT_CYCLES);
   localparam logic [BITS_d-1:0] c_CMD_WR  = BITS_d'(8'h57);  // 'W'
   localparam logic [BITS_d-1:0] c_CMD_RD  = BITS_d'(8'h52);  // 'R'
   localparam logic [BITS_d-1:0] c_RSP_OK  = BITS_d'(8'h4B);  // 'K'
   localparam logic [BITS_d-1:0] c_RSP_BAD = BITS_d'(8'h3F);  // '?'

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_POP      = 3'd1,
      S_LATCH    = 3'd2,
      S_EXEC_WR  = 3'd3,
      S_EXEC_RD  = 3'd4,
      S_RD_LATCH = 3'd5,
      S_SEND     = 3'd6
   } state_t;

   state_t                r_state;
   logic [1:0]            r_idx;      // 0 = cmd, 1 = addr, 2 = data
   logic [TCNT_W-1:0]     r_tcnt;
   logic [BITS_d-1:0]     r_cmd;
   logic [ADDR_BITS-1:0]  r_addr;
   logic [BITS_d-1:0]     r_wdata;
   logic [BITS_d-1:0]     r_resp;
   logic                  r_rd_uart;
   logic                  r_wr_uart;
   logic                  r_reg_we;
   logic                  r_reg_re;
   logic [7:0]            r_err;
   logic [7:0]            w_err_next;

   // Error counter sticks at its maximum instead of wrapping.
   assign w_err_next = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

   // Packet sequencer: every output is a register updated here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_idx     <= 2'd0;
         r_tcnt    <= '0;
         r_cmd     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_resp    <= '0;
         r_rd_uart <= 1'b0;
         r_wr_uart <= 1'b0;
         r_reg_we  <= 1'b0;
         r_reg_re  <= 1'b0;
         r_err     <= 8'd0;
      end else begin
         // Pop and bus strobes are single-cycle pulses by default.
         r_rd_uart <= 1'b0;
         r_reg_we  <= 1'b0;
         r_reg_re  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!rx_empty) begin
                  r_rd_uart <= 1'b1;
                  r_state   <= S_POP;
               end else if (r_idx != 2'd0) begin
                  // Stalled mid-packet: drop it silently once the budget is spent.
                  if (r_tcnt == c_TIMEOUT) begin
                     r_idx  <= 2'd0;
                     r_tcnt <= '0;
                     r_err  <= w_err_next;
                  end else begin
                     r_tcnt <= r_tcnt + TCNT_W'(1);
                  end
               end
            end
            S_POP: begin
               // FIFO presents the popped byte during the next cycle.
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               r_tcnt <= '0;
               case (r_idx)
                  2'd0: begin
                     r_cmd <= r_data;
                     if ((r_data == c_CMD_WR) || (r_data == c_CMD_RD)) begin
                        r_idx   <= 2'd1;
                        r_state <= S_IDLE;
                     end else begin
                        r_resp    <= c_RSP_BAD;
                        r_err     <= w_err_next;
                        r_idx     <= 2'd0;
                        r_wr_uart <= !tx_full;
                        r_state   <= S_SEND;
                     end
                  end
                  2'd1: begin
                     r_addr <= r_data[ADDR_BITS-1:0];
                     if (r_cmd == c_CMD_RD) begin
                        r_reg_re <= 1'b1;
                        r_state  <= S_EXEC_RD;
                     end else begin
                        r_idx   <= 2'd2;
                        r_state <= S_IDLE;
                     end
                  end
                  default: begin
                     r_wdata  <= r_data;
                     r_reg_we <= 1'b1;
                     r_state  <= S_EXEC_WR;
                  end
               endcase
            end
            S_EXEC_WR: begin
               r_resp    <= c_RSP_OK;
               r_wr_uart <= !tx_full;
               r_state   <= S_SEND;
            end
            S_EXEC_RD: begin
               // Read data arrives one cycle after the strobe.
               r_state <= S_RD_LATCH;
            end
            S_RD_LATCH: begin
               r_resp    <= reg_rdata;
               r_wr_uart <= !tx_full;
               r_state   <= S_SEND;
            end
            S_SEND: begin
               // A high push flag means this cycle is the push itself.
               if (r_wr_uart) begin
                  r_wr_uart <= 1'b0;
                  r_idx     <= 2'd0;
                  r_state   <= S_IDLE;
               end else if (!tx_full) begin
                  r_wr_uart <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_uart   = r_rd_uart;
   assign wr_uart   = r_wr_uart;
   assign w_data    = r_resp;
   assign reg_we    = r_reg_we;
   assign reg_re    = r_reg_re;
   assign reg_addr  = r_addr;
   assign reg_wdata = r_wdata;
   assign err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_reg_bridge
//  Description : Self-checking bench for uart_reg_bridge. Models the rx/tx
//                FIFOs and a register file, and predicts bus accesses,
//                responses and error count from a packet-level parser.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] r_data = 8'h00;
   logic       rx_empty = 1'b1;
   logic       rd_uart;
   logic [7:0] w_data;
   logic       wr_uart;
   logic       tx_full = 1'b0;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata = 8'h00;
   logic [7:0] err_count;

   int n_vec = 0;
   int n_err = 0;

   // Environment: FIFO contents, register file, observed tx bytes.
   logic [7:0] rxq[$];
   logic [7:0] regs[0:255];
   logic [7:0] tx_log[$];

   // Packet-level model: expected events and error total.
   logic [7:0] exp_wr_a[$];
   logic [7:0] exp_wr_d[$];
   logic [7:0] exp_rd[$];
   logic [7:0] exp_tx[$];
   logic [7:0] model_regs[0:255];
   int         model_err = 0;
   int         m_pos = 0;
   logic [7:0] m_cmd = 8'h00;
   logic [7:0] m_addr = 8'h00;
   logic [7:0] ea, ed;

   uart_reg_bridge #(
      .BITS_d(8), .ADDR_BITS(8), .TIMEOUT_CYCLES(20)
   ) dut (
      .clk(clk), .reset(reset),
      .r_data(r_data), .rx_empty(rx_empty), .rd_uart(rd_uart),
      .w_data(w_data), .wr_uart(wr_uart), .tx_full(tx_full),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: consume one host byte, predict what the bridge must do.
   task automatic model_step(input logic [7:0] b);
      if (m_pos == 0) begin
         if (b == 8'h57 || b == 8'h52) begin
            m_cmd = b;
            m_pos = 1;
         end else begin
            exp_tx.push_back(8'h3F);
            model_err = (model_err >= 255) ? 255 : model_err + 1;
         end
      end else if (m_pos == 1) begin
         m_addr = b;
         if (m_cmd == 8'h52) begin
            exp_rd.push_back(m_addr);
            exp_tx.push_back(model_regs[m_addr]);
            m_pos = 0;
         end else begin
            m_pos = 2;
         end
      end else begin
         exp_wr_a.push_back(m_addr);
         exp_wr_d.push_back(b);
         model_regs[m_addr] = b;
         exp_tx.push_back(8'h4B);
         m_pos = 0;
      end
   endtask

   task automatic model_timeout();
      m_pos = 0;
      model_err = (model_err >= 255) ? 255 : model_err + 1;
   endtask

   task automatic model_reset();
      m_pos = 0;
      model_err = 0;
      exp_tx.delete();
      exp_rd.delete();
      exp_wr_a.delete();
      exp_wr_d.delete();
   endtask

   task automatic feed(input logic [7:0] b);
      rxq.push_back(b);
      model_step(b);
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk);
      @(posedge clk); #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_tx.size() != 0 || exp_wr_a.size() != 0 || exp_rd.size() != 0 ||
              rxq.size() != 0) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= budget) check("drain_timeout", 1, 0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   // rx FIFO: pop on rd_uart, data visible the following cycle.
   always @(posedge clk) begin
      if (rd_uart) begin
         if (rxq.size() == 0) check("rd_uart_on_empty", 1, 0);
         else r_data <= rxq.pop_front();
      end
   end

   always @(negedge clk) rx_empty <= (rxq.size() == 0);

   // Register file slave.
   always @(posedge clk) begin
      if (reg_we) regs[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= regs[reg_addr];
   end

   // Compare process: every strobe/push checked against the model.
   always @(negedge clk) begin
      if (reg_we && reg_re) check("we_re_overlap", 1, 0);
      if (reg_we) begin
         if (exp_wr_a.size() == 0) check("unexpected_reg_we", 1, 0);
         else begin
            ea = exp_wr_a.pop_front();
            ed = exp_wr_d.pop_front();
            check("wr_addr", reg_addr, ea);
            check("wr_data", reg_wdata, ed);
         end
      end
      if (reg_re) begin
         if (exp_rd.size() == 0) check("unexpected_reg_re", 1, 0);
         else begin
            ea = exp_rd.pop_front();
            check("rd_addr", reg_addr, ea);
         end
      end
      if (wr_uart) begin
         tx_log.push_back(w_data);
         check("wr_uart_while_full", tx_full, 0);
         if (exp_tx.size() == 0) check("unexpected_wr_uart", 1, 0);
         else begin
            ea = exp_tx.pop_front();
            check("tx_byte", w_data, ea);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      for (int i = 0; i < 256; i++) begin
         regs[i]       = 8'(i ^ 8'h99);
         model_regs[i] = 8'(i ^ 8'h99);
      end
      regs[8'h22] = 8'h3C; model_regs[8'h22] = 8'h3C;
      regs[8'h05] = 8'h77; model_regs[8'h05] = 8'h77;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rd_uart", rd_uart, 0);
      check("rst_wr_uart", wr_uart, 0);
      check("rst_w_data", w_data, 0);
      check("rst_reg_we", reg_we, 0);
      check("rst_reg_re", reg_re, 0);
      check("rst_reg_addr", reg_addr, 0);
      check("rst_reg_wdata", reg_wdata, 0);
      check("rst_err_count", err_count, 0);
      reset = 1'b0;

      // Write 57 10 A5
      base = tx_log.size();
      feed(8'h57); feed(8'h10); feed(8'hA5);
      wait_drain(500);
      check("wr_tx_count", tx_log.size() - base, 1);
      check("wr_tx_K", tx_log[base], 8'h4B);
      check("wr_reg10", regs[8'h10], 8'hA5);
      check("wr_err", err_count, 0);

      // Read 52 22
      base = tx_log.size();
      feed(8'h52); feed(8'h22);
      wait_drain(500);
      check("rd_tx_count", tx_log.size() - base, 1);
      check("rd_tx_3C", tx_log[base], 8'h3C);

      // Unknown then recovery: 41 52 05
      do_reset();
      base = tx_log.size();
      feed(8'h41); feed(8'h52); feed(8'h05);
      wait_drain(500);
      check("unk_tx_count", tx_log.size() - base, 2);
      check("unk_tx_q", tx_log[base], 8'h3F);
      check("unk_tx_rd", tx_log[base+1], 8'h77);
      check("unk_err_lit", err_count, 1);
      check("unk_err_model", err_count, model_err);

      // Back-pressure during a write
      base = tx_log.size();
      tx_full = 1'b1;
      feed(8'h57); feed(8'h40); feed(8'h5A);
      n = 0;
      while (!reg_we && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_reg_we_seen", reg_we, 1);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         check("bp_hold_wr", wr_uart, 0);
      end
      tx_full = 1'b0;
      @(posedge clk); #1;
      check("bp_release_wr", wr_uart, 1);
      check("bp_release_data", w_data, 8'h4B);
      @(posedge clk); #1;
      check("bp_single_pulse", wr_uart, 0);
      wait_drain(200);
      check("bp_tx_count", tx_log.size() - base, 1);
      check("bp_reg40", regs[8'h40], 8'h5A);

      // Timeout: 57 10, starve, then 52 10
      do_reset();
      base = tx_log.size();
      feed(8'h57); feed(8'h10);
      n = 0;
      while (rxq.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (25) @(posedge clk);
      #1;
      model_timeout();
      check("to_err_lit", err_count, 1);
      feed(8'h52); feed(8'h10);
      wait_drain(500);
      check("to_tx_count", tx_log.size() - base, 1);
      check("to_tx_rd", tx_log[base], 8'hA5);
      check("to_reg10_kept", regs[8'h10], 8'hA5);
      check("to_err_model", err_count, model_err);

      // Reset while in EXEC_RD
      base = tx_log.size();
      feed(8'h52); feed(8'h30);
      n = 0;
      while (!reg_re && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("rs_reg_re_seen", reg_re, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rs_rd_uart", rd_uart, 0);
      check("rs_wr_uart", wr_uart, 0);
      check("rs_w_data", w_data, 0);
      check("rs_reg_we", reg_we, 0);
      check("rs_reg_re", reg_re, 0);
      check("rs_reg_addr", reg_addr, 0);
      check("rs_reg_wdata", reg_wdata, 0);
      check("rs_err_count", err_count, 0);
      model_reset();
      @(posedge clk); #1 reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("rs_no_push", tx_log.size() - base, 0);
      feed(8'h57); feed(8'h01); feed(8'h02);
      wait_drain(500);
      check("rs_after_tx", tx_log[tx_log.size()-1], 8'h4B);
      check("rs_after_reg01", regs[8'h01], 8'h02);

      // Error counter saturation
      do_reset();
      for (int i = 0; i < 258; i++) feed(8'h00);
      wait_drain(4000);
      check("sat_err_lit", err_count, 8'd255);
      check("sat_err_model", err_count, model_err);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Command engine downstream of the UART receive FIFO and upstream of the UART transmit FIFO. It pops bytes from the rx side (`r_data`/`rd_uart`/`rx_empty`), decodes a 2- or 3-byte command packet, performs a single register read or write on a simple synchronous register bus, and pushes a one-byte response into the tx side (`w_data`/`wr_uart`/`tx_full`). It lets a host PC poke and peek design registers over the serial link.

## Interface
- `BITS_d`, 8: data width of UART bytes and register data.
- `ADDR_BITS`, 8: register address width; the address is the low `ADDR_BITS` of the address byte.
- `TIMEOUT_CYCLES`, 1_000_000: idle clocks allowed between bytes of one packet before the packet is discarded.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `r_data` in BITS_d: rx FIFO output; valid the cycle after `rd_uart` was high.
- `rx_empty` in 1: rx FIFO empty.
- `rd_uart` out 1: rx FIFO pop, one-cycle pulse.
- `w_data` out BITS_d: response byte to the tx FIFO.
- `wr_uart` out 1: tx FIFO push, one-cycle pulse.
- `tx_full` in 1: tx FIFO full.
- `reg_addr` out ADDR_BITS: register address.
- `reg_wdata` out BITS_d: register write data.
- `reg_we` out 1: register write strobe, one cycle.
- `reg_re` out 1: register read strobe, one cycle.
- `reg_rdata` in BITS_d: read data, valid the cycle after `reg_re`.
- `err_count` out 8: saturating count of protocol errors (unknown command or timeout).

## Operation
- Packets: write = 0x57 ('W'), addr, data → reg write, response 0x4B ('K'). Read = 0x52 ('R'), addr → reg read, response = read data. Any other first byte → response 0x3F ('?'); the byte is consumed and `err_count` increments.
- Byte index `idx` (0 = cmd, 1 = addr, 2 = data) tracks packet position. Command, address and data are held in registers.
- FSM states: IDLE, POP, LATCH, EXEC_WR, EXEC_RD, RD_LATCH, SEND.
  - IDLE: if `!rx_empty` go to POP. Otherwise, if `idx != 0`, increment the timeout counter.
  - POP: `rd_uart` = 1; go to LATCH.
  - LATCH: capture `r_data` into the register selected by `idx`; clear the timeout counter. Next state:
    - cmd unknown → SEND ('?'), `err_count`++, `idx` = 0.
    - packet complete → EXEC_WR or EXEC_RD.
    - otherwise → IDLE with `idx`+1.
  - EXEC_WR: `reg_we` = 1, `reg_addr`/`reg_wdata` driven; response 'K'; go to SEND.
  - EXEC_RD: `reg_re` = 1; go to RD_LATCH.
  - RD_LATCH: capture `reg_rdata` as the response; go to SEND.
  - SEND: hold while `tx_full`. When `!tx_full`: `wr_uart` = 1 with `w_data` = response, `idx` = 0, go to IDLE.
- Timeout: when the counter reaches `TIMEOUT_CYCLES` in IDLE with `idx != 0`:
  - `idx` = 0, counter = 0, `err_count`++.
  - No response is sent and the partial packet is dropped.
  - The counter never runs while `idx == 0`.
- `err_count` saturates at 255; it does not wrap.
- Bytes arriving during EXEC/SEND stay in the rx FIFO. They are never dropped by this block.

## Timing
- Reset: state IDLE, `idx` 0, timeout counter 0. All outputs 0: `rd_uart`, `wr_uart`, `w_data`, `reg_we`, `reg_re`, `reg_addr`, `reg_wdata`, `err_count`.
- All outputs are registered or decoded from the registered state. There is no combinational path from any input to any output.
- Each byte costs 3 cycles (IDLE→POP→LATCH) when the FIFO is non-empty.
- Write packet with all bytes present: `reg_we` 1 cycle after the third LATCH; `wr_uart` 1 cycle later if `!tx_full`.
- Read packet: `reg_re` 1 cycle after the second LATCH; `wr_uart` 2 cycles after `reg_re`.
- `rd_uart` is never asserted while `rx_empty` was sampled high in the preceding IDLE cycle. `wr_uart` is never asserted while `tx_full` = 1.
- Reset mid-packet or mid-SEND aborts immediately: no strobe is issued and no push occurs in the reset cycle or after it.

## Test plan
- Write: preload rx with 57 10 A5 → exactly one `reg_we` with addr 0x10, data 0xA5; tx receives 0x4B; `err_count` 0.
- Read: register model returns 0x3C at 0x22; rx 52 22 → one `reg_re` with addr 0x22; tx receives 0x3C.
- Unknown plus recovery: rx 41 52 05 → tx receives 3F, then the reg[0x05] value; `err_count` = 1.
- Back-pressure: hold `tx_full` = 1 for 50 cycles during a write → `wr_uart` stays low; it fires once on the first cycle after release; exactly one 0x4B.
- Timeout: with TIMEOUT_CYCLES = 20, send 57 10, then starve 25 cycles, then 52 10 → no write, `err_count` = 1, tx gets only the read response.
- Reset: assert `reset` in EXEC_RD → all outputs 0 the next cycle; a following 57 01 02 completes normally.
